// File: rtl/round_engine.sv
// rtl/round_engine.sv - iterative 8-bit round datapath around an external substitution block
// Each round: key mix, external substitution, rotl-3 permutation; final key whitening.
module round_engine #(
  parameter int ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] key,
  output logic [7:0] sub_in,
  input  logic [7:0] sub_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LP_LAST   = 4'(ROUNDS - 1);
  localparam logic [3:0] LP_ROUNDS = 4'(ROUNDS);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_s;
  logic [7:0] r_k;
  logic [3:0] r_r;
  logic [7:0] r_out_data;
  logic [7:0] w_perm;
  logic [7:0] w_final_key;

  // rk(r) = rotl(k, r[2:0]) ^ r; the upper byte of {k,k} << n is rotl(k, n)
  function automatic logic [7:0] f_round_key(input logic [7:0] k, input logic [3:0] r);
    logic [15:0] w_dbl;
    w_dbl = {k, k} << r[2:0];
    return w_dbl[15:8] ^ {4'b0000, r};
  endfunction

  assign sub_in      = r_s ^ f_round_key(r_k, r_r);
  assign w_perm      = {sub_out[4:0], sub_out[7:5]};
  assign w_final_key = f_round_key(r_k, LP_ROUNDS);
  assign out_data    = r_out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = ROUND;
      ROUND:   if (r_r == LP_LAST) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == ROUND) || (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s        <= 8'h00;
      r_k        <= 8'h00;
      r_r        <= 4'h0;
      r_out_data <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_s <= in_data;
            r_k <= key;
            r_r <= 4'h0;
          end
        end
        ROUND: begin
          r_s <= w_perm;
          r_r <= r_r + 4'h1;
          if (r_r == LP_LAST) begin
            r_out_data <= w_perm ^ w_final_key;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_round_engine.sv
// tb/tb_round_engine.sv - directed bench for round_engine with identity substitution
// Three instances (ROUNDS=1,2,4) share the input side so one stimulus checks all depths.
module tb_round_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] key;
  logic       out_ready;

  logic       in_ready_1, out_valid_1, busy_1;
  logic [7:0] sub_in_1, out_data_1;
  logic       in_ready_2, out_valid_2, busy_2;
  logic [7:0] sub_in_2, out_data_2;
  logic       in_ready_4, out_valid_4, busy_4;
  logic [7:0] sub_in_4, out_data_4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  round_engine #(.ROUNDS(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_data(in_data), .key(key), .sub_in(sub_in_1), .sub_out(sub_in_1),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_data(out_data_1), .busy(busy_1)
  );

  round_engine #(.ROUNDS(2)) u_r2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_2),
    .in_data(in_data), .key(key), .sub_in(sub_in_2), .sub_out(sub_in_2),
    .out_valid(out_valid_2), .out_ready(out_ready), .out_data(out_data_2), .busy(busy_2)
  );

  round_engine #(.ROUNDS(4)) u_r4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
    .in_data(in_data), .key(key), .sub_in(sub_in_4), .sub_out(sub_in_4),
    .out_valid(out_valid_4), .out_ready(out_ready), .out_data(out_data_4), .busy(busy_4)
  );

  typedef struct {
    logic [7:0] din;
    logic [7:0] k;
    logic [7:0] exp1;
    logic [7:0] exp2;
    logic [7:0] exp4;
  } vec_t;

  vec_t vecs[5];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (!(in_ready_1 && in_ready_2 && in_ready_4) && n < 40) begin
      tick;
      n++;
    end
    if (n >= 40) check_int("wait_idle_timeout", n, 0);
  endtask

  task automatic run_vec(input logic [7:0] din, input logic [7:0] k, input bit scramble,
                         output logic [7:0] d1, output logic [7:0] d2, output logic [7:0] d4,
                         output int l1, output int l2, output int l4);
    l1 = -1; l2 = -1; l4 = -1;
    d1 = 8'h00; d2 = 8'h00; d4 = 8'h00;
    wait_idle;
    in_data  = din;
    key      = k;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (scramble) begin
        in_data = 8'($urandom);
        key     = 8'($urandom);
      end
      tick;
      if (out_valid_1 && l1 < 0) begin l1 = n; d1 = out_data_1; end
      if (out_valid_2 && l2 < 0) begin l2 = n; d2 = out_data_2; end
      if (out_valid_4 && l4 < 0) begin l4 = n; d4 = out_data_4; end
    end
  endtask

  initial begin
    logic [7:0] d1, d2, d4;
    int l1, l2, l4;
    int viol;
    int acc_cnt;
    int acc_t[8];
    int data_bad;

    vecs[0] = '{8'h00, 8'h00, 8'h01, 8'h0A, 8'h9E};
    vecs[1] = '{8'h01, 8'h00, 8'h09, 8'h4A, 8'h8E};
    vecs[2] = '{8'h00, 8'h01, 8'h0B, 8'h5E, 8'hDB};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 8'h0A, 8'h9E};
    vecs[4] = '{8'hA5, 8'h3C, 8'hB5, 8'h5F, 8'h07};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; key = 8'h00; out_ready = 1'b1;
    #12;
    check8("rst_in_ready", 8'(in_ready_4), 8'h01);
    check8("rst_out_valid", 8'(out_valid_4), 8'h00);
    check8("rst_out_data", out_data_4, 8'h00);
    check8("rst_busy", 8'(busy_4), 8'h00);
    check8("rst_sub_in", sub_in_4, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_vec(vecs[i].din, vecs[i].k, i == 4, d1, d2, d4, l1, l2, l4);
      check8($sformatf("vec%0d_r1_data", i), d1, vecs[i].exp1);
      check8($sformatf("vec%0d_r2_data", i), d2, vecs[i].exp2);
      check8($sformatf("vec%0d_r4_data", i), d4, vecs[i].exp4);
      check_int($sformatf("vec%0d_r1_lat", i), l1, 1);
      check_int($sformatf("vec%0d_r2_lat", i), l2, 2);
      check_int($sformatf("vec%0d_r4_lat", i), l4, 4);
    end

    // sub_in sequence on the two-round instance
    wait_idle;
    in_data = 8'h00; key = 8'h00; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check8("r2_sub_in_0", sub_in_2, 8'h00);
    check8("r2_busy_after_a", 8'(busy_2), 8'h01);
    tick;
    check8("r2_sub_in_1", sub_in_2, 8'h01);
    tick;
    check8("r2_out_valid_a2", 8'(out_valid_2), 8'h01);
    check8("r2_out_data_a2", out_data_2, 8'h0A);
    repeat (6) tick;

    // backpressure with an ignored in_valid pulse
    out_ready = 1'b0;
    wait_idle;
    in_data = 8'hA5; key = 8'h3C; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    check8("bp_out_valid", 8'(out_valid_4), 8'h01);
    check8("bp_out_data", out_data_4, 8'h07);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      in_data  = 8'hFF;
      key      = 8'hFF;
      tick;
      if (!(out_valid_4 && out_data_4 == 8'h07 && !in_ready_4 && busy_4)) viol++;
    end
    in_valid = 1'b0;
    check_int("bp_hold_violations", viol, 0);
    out_ready = 1'b1;
    check8("bp_in_ready_before_d", 8'(in_ready_4), 8'h00);
    tick;
    check8("bp_in_ready_after_d", 8'(in_ready_4), 8'h01);
    check8("bp_out_valid_after_d", 8'(out_valid_4), 8'h00);
    check8("bp_busy_after_d", 8'(busy_4), 8'h00);
    viol = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid_4) viol++;
    end
    check_int("bp_ignored_pulse", viol, 0);

    // asynchronous reset during round 2
    wait_idle;
    in_data = 8'h01; key = 8'h00; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    check8("arst_in_ready", 8'(in_ready_4), 8'h01);
    check8("arst_out_valid", 8'(out_valid_4), 8'h00);
    check8("arst_out_data", out_data_4, 8'h00);
    check8("arst_busy", 8'(busy_4), 8'h00);
    check8("arst_sub_in", sub_in_4, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (out_valid_1 || out_valid_2 || out_valid_4) viol++;
    end
    check_int("arst_no_spurious_valid", viol, 0);
    run_vec(8'hA5, 8'h3C, 1'b1, d1, d2, d4, l1, l2, l4);
    check8("arst_fresh_r4_data", d4, 8'h07);
    check_int("arst_fresh_r4_lat", l4, 4);

    // back-to-back with out_ready held high
    wait_idle;
    in_data = 8'h00; key = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
    acc_cnt = 0;
    data_bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_valid && in_ready_4 && acc_cnt < 8) begin
        acc_t[acc_cnt] = c;
        acc_cnt++;
      end
      if (out_valid_4 && out_data_4 != 8'h9E) data_bad++;
    end
    in_valid = 1'b0;
    check_int("b2b_data_errors", data_bad, 0);
    check_int("b2b_accept_count", acc_cnt, 7);
    for (int i = 1; i < 4; i++) begin
      if (i < acc_cnt) check_int($sformatf("b2b_gap%0d", i), acc_t[i] - acc_t[i-1], 6);
    end
    repeat (10) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
